// File: rtl/euler_accumulator.sv
// Accumulator stage of the Euler update: q = narrow(y_init + sum of NumTerms signed products).
// Optional macro ACC_SAT_EN: saturate the narrowed result and flag ovf; otherwise wrap, ovf = 0.
module euler_accumulator #(
   parameter int Size      = 8,
   parameter int NumTerms  = 4,
   parameter int GuardBits = 3
) (
   input  logic            clk,
   input  logic            rst_sync,
   input  logic            start,
   input  logic [Size-1:0] y_init,
   input  logic            done_mul_in,
   input  logic [Size-1:0] d,
   output logic            busy,
   output logic            done_acc,
   output logic [Size-1:0] q,
   output logic            ovf
);
   localparam int AccW = Size + GuardBits;
   localparam int CntW = (NumTerms > 1) ? $clog2(NumTerms) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumTerms - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                 state, state_d;
   logic signed [AccW-1:0] acc, acc_d;
   logic signed [AccW-1:0] y_ext, d_ext;
   logic [CntW-1:0]        count, count_d;
   logic [Size-1:0]        q_d, res_narrow;
   logic                   ovf_d, ovf_narrow, done_d, busy_d;

   assign y_ext = {{GuardBits{y_init[Size-1]}}, y_init};
   assign d_ext = {{GuardBits{d[Size-1]}}, d};

`ifdef ACC_SAT_EN
   localparam logic signed [AccW-1:0] MaxVal = AccW'((2 ** (Size - 1)) - 1);
   localparam logic signed [AccW-1:0] MinVal = AccW'(-(2 ** (Size - 1)));

   always_comb begin
      res_narrow = acc[Size-1:0];
      ovf_narrow = 1'b0;
      if (acc > MaxVal) begin
         res_narrow = MaxVal[Size-1:0];
         ovf_narrow = 1'b1;
      end else if (acc < MinVal) begin
         res_narrow = MinVal[Size-1:0];
         ovf_narrow = 1'b1;
      end
   end
`else
   assign res_narrow = acc[Size-1:0];
   assign ovf_narrow = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state;
      acc_d   = acc;
      count_d = count;
      q_d     = q;
      ovf_d   = ovf;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               acc_d   = y_ext;
               count_d = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (done_mul_in) begin
               acc_d   = acc + d_ext;
               count_d = count + 1'b1;
               if (count == LastCnt) state_d = DONE;
            end
         end
         DONE: begin
            q_d     = res_narrow;
            ovf_d   = ovf_narrow;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state    <= IDLE;
         acc      <= '0;
         count    <= '0;
         q        <= '0;
         ovf      <= 1'b0;
         done_acc <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         acc      <= acc_d;
         count    <= count_d;
         q        <= q_d;
         ovf      <= ovf_d;
         done_acc <= done_d;
         busy     <= busy_d;
      end
   end
endmodule
